// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, fetch/sequencer state encoding and opcode constants
//
// Contents:
//   OP_W, OPND_W, PC_W  default field and program-counter widths
//   cpuState            sequencer state enumeration
//   OP_*                opcode values seen by the decoder
package cpu_pkg;

  localparam int OP_W   = 4;
  localparam int OPND_W = 8;
  localparam int PC_W   = 8;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_HALT    = 3'd4
  } cpuState;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_LDA = 4'd2;
  localparam logic [3:0] OP_STA = 4'd3;
  localparam logic [3:0] OP_LDB = 4'd4;
  localparam logic [3:0] OP_STB = 4'd5;
  localparam logic [3:0] OP_LDC = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8;
  localparam logic [3:0] OP_OR  = 4'd9;
  localparam logic [3:0] OP_BEQ = 4'd10;
  localparam logic [3:0] OP_HLT = 4'd15;

endpackage

// File: rtl/sequenciador_busca_contador_programa.sv
// rtl/sequenciador_busca_contador_programa.sv - program counter register with load and increment
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset, clears the counter
//   loadEn     load loadValue (takes priority over incEn)
//   incEn      advance by one, wrapping modulo 2^PC_W
//   loadValue  branch target
//   pcValue    current program counter
module contador_programa
  import cpu_pkg::*;
#(
  parameter int PC_W = cpu_pkg::PC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            loadEn,
  input  logic            incEn,
  input  logic [PC_W-1:0] loadValue,
  output logic [PC_W-1:0] pcValue
);

  // Plain PC_W-bit addition gives the wrap from all-ones back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcValue <= '0;
    end else if (loadEn) begin
      pcValue <= loadValue;
    end else if (incEn) begin
      pcValue <= pcValue + PC_W'(1);
    end
  end

endmodule

// File: rtl/sequenciador_busca.sv
// rtl/sequenciador_busca.sv - multi-cycle fetch/sequencing stage ahead of the opcode decoder
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   imem_req/imem_addr              instruction fetch request and address (= pc)
//   imem_rdata/imem_ready           instruction word and its valid strobe
//   opcode/operand                  instruction register fields for the decoder
//   pc                              current program counter
//   mem_read/mem_write              decoder memory controls
//   branch_zero/branch_eq           decoder jump / branch-if-equal controls
//   eq_flag                         datapath equality flag, used in EXECUTE
//   exec_en                         one-cycle execute strobe
//   dmem_req/dmem_ready             data access request and completion
//   halted                          core stopped on HLT
module sequenciador_busca
  import cpu_pkg::*;
#(
  parameter int OP_W   = cpu_pkg::OP_W,
  parameter int OPND_W = cpu_pkg::OPND_W,
  parameter int PC_W   = cpu_pkg::PC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [PC_W-1:0]        imem_addr,
  input  logic [OP_W+OPND_W-1:0] imem_rdata,
  input  logic                   imem_ready,
  output logic [OP_W-1:0]        opcode,
  output logic [OPND_W-1:0]      operand,
  output logic [PC_W-1:0]        pc,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic                   branch_zero,
  input  logic                   branch_eq,
  input  logic                   eq_flag,
  output logic                   exec_en,
  output logic                   dmem_req,
  input  logic                   dmem_ready,
  output logic                   halted
);

  cpuState                 state;
  logic [OP_W+OPND_W-1:0]  instrReg;
  logic                    imemReqQ;
  logic                    execEnQ;
  logic                    dmemReqQ;
  logic                    haltedQ;

  logic                    isMemOp;
  logic                    takeBranch;
  logic                    pcLoad;
  logic                    pcInc;
  logic [PC_W-1:0]         branchTarget;

  assign opcode  = instrReg[OP_W+OPND_W-1:OPND_W];
  assign operand = instrReg[OPND_W-1:0];

  // Branch targets come from the operand: truncated or zero-extended to PC_W.
  generate
    if (OPND_W >= PC_W) begin : gTargetTrunc
      assign branchTarget = operand[PC_W-1:0];
    end else begin : gTargetExt
      assign branchTarget = {{(PC_W-OPND_W){1'b0}}, operand};
    end
  endgenerate

  // A memory instruction always takes the memory path, even if a branch
  // control is also high; branch_zero outranks branch_eq inside takeBranch.
  assign isMemOp    = mem_read | mem_write;
  assign takeBranch = branch_zero | (branch_eq & eq_flag);

  always_comb begin
    pcLoad = 1'b0;
    pcInc  = 1'b0;
    if (state == S_EXECUTE && !isMemOp) begin
      if (takeBranch) begin
        pcLoad = 1'b1;
      end else begin
        pcInc = 1'b1;
      end
    end else if (state == S_MEM && dmem_ready) begin
      pcInc = 1'b1;
    end
  end

  contador_programa #(
    .PC_W (PC_W)
  ) uContador (
    .clk       (clk),
    .rst       (rst),
    .loadEn    (pcLoad),
    .incEn     (pcInc),
    .loadValue (branchTarget),
    .pcValue   (pc)
  );

  assign imem_addr = pc;
  assign imem_req  = imemReqQ;
  assign exec_en   = execEnQ;
  assign dmem_req  = dmemReqQ;
  assign halted    = haltedQ;

  // Sequencer. Outputs are registered alongside the state they belong to.
  // Leaving reset, FETCH spends one cycle raising imem_req before it will
  // accept a word, so imem_ready is only honoured while the request is out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      instrReg <= '0;
      imemReqQ <= 1'b0;
      execEnQ  <= 1'b0;
      dmemReqQ <= 1'b0;
      haltedQ  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!imemReqQ) begin
            imemReqQ <= 1'b1;
          end else if (imem_ready) begin
            instrReg <= imem_rdata;
            imemReqQ <= 1'b0;
            state    <= S_DECODE;
          end
        end

        // One settling cycle for the decoder driven from the new IR.
        S_DECODE: begin
          if (opcode == OP_W'(OP_HLT)) begin
            haltedQ <= 1'b1;
            state   <= S_HALT;
          end else begin
            execEnQ <= 1'b1;
            state   <= S_EXECUTE;
          end
        end

        S_EXECUTE: begin
          execEnQ <= 1'b0;
          if (isMemOp) begin
            dmemReqQ <= 1'b1;
            state    <= S_MEM;
          end else begin
            imemReqQ <= 1'b1;
            state    <= S_FETCH;
          end
        end

        S_MEM: begin
          if (dmem_ready) begin
            dmemReqQ <= 1'b0;
            imemReqQ <= 1'b1;
            state    <= S_FETCH;
          end
        end

        S_HALT: begin
          haltedQ <= 1'b1;
        end

        default: begin
          imemReqQ <= 1'b0;
          execEnQ  <= 1'b0;
          dmemReqQ <= 1'b0;
          haltedQ  <= 1'b0;
          state    <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequenciador_busca.sv
// tb/tb_sequenciador_busca.sv - self-checking bench for sequenciador_busca
module tb_sequenciador_busca;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [11:0] imem_rdata;
  logic        imem_ready;
  logic [3:0]  opcode;
  logic [7:0]  operand;
  logic [7:0]  pc;
  logic        mem_read, mem_write, branch_zero, branch_eq;
  logic        eq_flag;
  logic        exec_en;
  logic        dmem_req;
  logic        dmem_ready;
  logic        halted;

  int checks = 0;
  int errors = 0;

  int          modelPc;
  logic [11:0] modelIr;
  logic        ovrEn, ovrMr, ovrMw, ovrBz, ovrBeq;

  always #5 clk = ~clk;

  sequenciador_busca dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .opcode      (opcode),
    .operand     (operand),
    .pc          (pc),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .branch_zero (branch_zero),
    .branch_eq   (branch_eq),
    .eq_flag     (eq_flag),
    .exec_en     (exec_en),
    .dmem_req    (dmem_req),
    .dmem_ready  (dmem_ready),
    .halted      (halted)
  );

  // Decoder stand-in: {MemRead, MemWrite, BranchZero, BranchEQ} per opcode.
  function automatic logic [3:0] decodeCtl(input logic [3:0] op);
    case (op)
      OP_LDA, OP_LDB, OP_LDC: return 4'b1000;
      OP_STA, OP_STB:         return 4'b0100;
      OP_JMP:                 return 4'b0010;
      OP_BEQ:                 return 4'b0001;
      default:                return 4'b0000;
    endcase
  endfunction

  always_comb begin
    {mem_read, mem_write, branch_zero, branch_eq} = decodeCtl(opcode);
    if (ovrEn) {mem_read, mem_write, branch_zero, branch_eq} = {ovrMr, ovrMw, ovrBz, ovrBeq};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then scatter noise on inputs the DUT must ignore here.
  task automatic tick();
    @(posedge clk);
    #1;
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    imem_rdata = 12'($urandom);
  endtask

  // Runs one instruction starting in FETCH with imem_req already up.
  task automatic runInstr(input logic [11:0] instr, input int iWait, input int dWait, input logic eq);
    logic [3:0] ctl;
    int         nextPc;
    check("fetch_req", imem_req, 1);
    check("fetch_addr", imem_addr, modelPc);
    for (int i = 0; i < iWait; i++) begin
      imem_ready = 1'b0;
      tick();
      check("wait_req", imem_req, 1);
      check("wait_addr", imem_addr, modelPc);
      check("wait_ir", {opcode, operand}, modelIr);
    end
    imem_ready = 1'b1;
    imem_rdata = instr;
    tick();
    modelIr = instr;
    check("decode_ir", {opcode, operand}, instr);
    check("decode_req", imem_req, 0);
    check("decode_exec", exec_en, 0);
    if (instr[11:8] == 4'hF) begin
      tick();
      check("halt_flag", halted, 1);
      check("halt_req", imem_req, 0);
      return;
    end
    eq_flag = eq;
    tick();
    check("exec_en", exec_en, 1);
    check("exec_pc", pc, modelPc);
    ctl = ovrEn ? {ovrMr, ovrMw, ovrBz, ovrBeq} : decodeCtl(instr[11:8]);
    if (ctl[3] | ctl[2])                 nextPc = (modelPc + 1) % 256;
    else if (ctl[1])                     nextPc = instr[7:0];
    else if (ctl[0] && eq)               nextPc = instr[7:0];
    else                                 nextPc = (modelPc + 1) % 256;
    if (ctl[3] | ctl[2]) begin
      tick();
      check("mem_req", dmem_req, 1);
      check("mem_exec", exec_en, 0);
      check("mem_pc", pc, modelPc);
      for (int i = 0; i < dWait; i++) begin
        dmem_ready = 1'b0;
        tick();
        check("mem_wait_req", dmem_req, 1);
        check("mem_wait_pc", pc, modelPc);
      end
      dmem_ready = 1'b1;
    end
    tick();
    modelPc = nextPc;
    check("next_req", imem_req, 1);
    check("next_addr", imem_addr, modelPc);
    check("next_exec", exec_en, 0);
    check("next_dmem", dmem_req, 0);
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = '0; eq_flag = 1'b0;
    ovrEn = 1'b0; ovrMr = 1'b0; ovrMw = 1'b0; ovrBz = 1'b0; ovrBeq = 1'b0;
    modelPc = 0; modelIr = '0;

    // Reset: two cycles, then release with a word already offered.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_req", imem_req, 0);
      check("rst_pc", pc, 0);
      check("rst_exec", exec_en, 0);
      check("rst_dmem", dmem_req, 0);
      check("rst_halt", halted, 0);
      check("rst_ir", {opcode, operand}, 0);
    end
    rst = 1'b0; imem_ready = 1'b1; imem_rdata = 12'h005;
    tick();
    check("rel_req", imem_req, 1);
    check("rel_addr", imem_addr, 0);
    check("rel_ir", {opcode, operand}, 0);
    runInstr(12'h005, 0, 0, 1'b0);

    // Walk to pc=4, then three instruction wait states.
    for (int i = 0; i < 3; i++) runInstr(12'h8AA, 0, 0, 1'b0);
    runInstr(12'h1AB, 3, 0, 1'b0);

    // Branches.
    runInstr(12'h720, 0, 0, 1'b0);
    runInstr(12'hA30, 0, 0, 1'b0);
    runInstr(12'hA30, 1, 0, 1'b1);
    ovrEn = 1'b1; ovrBz = 1'b1; ovrBeq = 1'b1;
    runInstr(12'h077, 0, 0, 1'b0);
    ovrMr = 1'b1;
    runInstr(12'h299, 0, 0, 1'b1);
    ovrEn = 1'b0; ovrMr = 1'b0; ovrBz = 1'b0; ovrBeq = 1'b0;

    // Memory access with two data wait states.
    runInstr(12'h240, 0, 2, 1'b0);

    // Wrap through an undefined opcode at pc=0xFF.
    runInstr(12'h7FF, 0, 0, 1'b0);
    runInstr(12'hC00, 0, 0, 1'b0);

    // Random instruction stream (no HLT).
    for (int n = 0; n < 40; n++) begin
      logic [11:0] w;
      w = {4'($urandom_range(0, 14)), 8'($urandom)};
      runInstr(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Reset during a data wait.
    imem_ready = 1'b1; imem_rdata = 12'h512;
    tick(); tick(); tick();
    check("mid_mem_req", dmem_req, 1);
    dmem_ready = 1'b0;
    tick();
    rst = 1'b1; dmem_ready = 1'b0;
    tick();
    check("midrst_dmem", dmem_req, 0);
    check("midrst_pc", pc, 0);
    check("midrst_ireq", imem_req, 0);
    rst = 1'b0;
    tick();
    modelPc = 0; modelIr = '0;
    check("midrst_ir", {opcode, operand}, 0);
    runInstr(12'h933, 0, 0, 1'b0);

    // Halt, then only reset leaves it.
    runInstr(12'hF00, 1, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_halt", halted, 1);
      check("hold_ireq", imem_req, 0);
      check("hold_dreq", dmem_req, 0);
    end
    rst = 1'b1;
    tick();
    check("unhalt_flag", halted, 0);
    check("unhalt_pc", pc, 0);
    rst = 1'b0;
    tick();
    check("unhalt_req", imem_req, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
